// File: rtl/shiftreg1_8.sv
// Serial-in, parallel-out receiver with valid/ack handshake and sticky overrun.
// Optional even-parity trailer bit enabled by defining SHIFTREG1_8_PARITY_EN.
module shiftreg1_8 #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             D,
    input  logic             DIR,
    input  logic             SYNC,
    input  logic             ACK,
    output logic [WIDTH-1:0] DATA,
    output logic             VLD,
    output logic             OVR,
    output logic             BUSY,
    output logic             PERR
);

`ifdef SHIFTREG1_8_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif

    logic [WIDTH-1:0] r_shreg;
    logic [CNT_W-1:0] r_cnt;
    logic             r_dir;
    logic [WIDTH-1:0] r_data;
    logic             r_vld;
    logic             r_ovr;

    logic [WIDTH-1:0] w_sh_cur;
    logic [WIDTH-1:0] w_shift;
    logic [WIDTH-1:0] w_sh_nxt;
    logic [CNT_W-1:0] w_cnt_cur;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_dir_eff;
    logic             w_dir_nxt;
    logic             w_data_bit;
    logic             w_last;

    // SYNC behaves as if the counter and shifter were already cleared this cycle,
    // so a coincident strobe starts a fresh frame.
    always_comb begin
        w_cnt_cur  = SYNC ? '0 : r_cnt;
        w_sh_cur   = SYNC ? '0 : r_shreg;
        w_dir_eff  = (w_cnt_cur == '0) ? DIR : r_dir;
        w_dir_nxt  = (EN && (w_cnt_cur == '0)) ? DIR : r_dir;
        w_shift    = w_dir_eff ? {w_sh_cur[WIDTH-2:0], D} : {D, w_sh_cur[WIDTH-1:1]};
`ifdef SHIFTREG1_8_PARITY_EN
        w_data_bit = (w_cnt_cur < CNT_W'(WIDTH));
`else
        w_data_bit = 1'b1;
`endif
        w_last     = EN && (w_cnt_cur == CNT_W'(FRAME - 1));
        w_sh_nxt   = (EN && w_data_bit) ? w_shift : w_sh_cur;
        w_cnt_nxt  = w_cnt_cur;
        if (EN)
            w_cnt_nxt = w_last ? '0 : w_cnt_cur + 1'b1;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_shreg <= '0;
            r_cnt   <= '0;
            r_dir   <= 1'b1;
        end else begin
            r_shreg <= w_last ? '0 : w_sh_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dir   <= w_dir_nxt;
        end
    end

    // A completing frame always wins over ACK; overrun only if the old word was not taken.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_data <= '0;
            r_vld  <= 1'b0;
            r_ovr  <= 1'b0;
        end else if (w_last) begin
            r_data <= w_sh_nxt;
            r_vld  <= 1'b1;
            r_ovr  <= r_vld && !ACK;
        end else if (ACK && r_vld) begin
            r_vld  <= 1'b0;
            r_ovr  <= 1'b0;
        end
    end

`ifdef SHIFTREG1_8_PARITY_EN
    logic r_perr;

    // Parity bit is the last strobe of the frame and is only folded into PERR.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            r_perr <= 1'b0;
        else if (w_last)
            r_perr <= (^w_sh_cur) ^ D;
        else if (ACK && r_vld)
            r_perr <= 1'b0;
    end

    assign PERR = r_perr;
`else
    assign PERR = 1'b0;
`endif

    assign DATA = r_data;
    assign VLD  = r_vld;
    assign OVR  = r_ovr;
    assign BUSY = (r_cnt != '0);

endmodule
